// File: rtl/rob_multiport.sv
// rob_multiport: circular reorder buffer with DISP_WIDTH-wide in-order
// allocation, WB_PORTS out-of-order completion ports and RETIRE_WIDTH-wide
// in-order retirement. A retiring entry that mispredicted or raised an
// exception retires in its own lane, blocks the lanes after it, and triggers
// a precise flush of everything younger.
// Optional feature macro: ROB_PERF_CNT_EN enables the saturating performance
// counters. When it is undefined, the perf ports are tied to zero.
module rob_multiport #(
  parameter int ROB_ENTRIES  = 16,
  parameter int DISP_WIDTH   = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int WB_PORTS     = 4,
  parameter int IDXW         = $clog2(ROB_ENTRIES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DISP_WIDTH-1:0]        disp_valid,
  input  logic [DISP_WIDTH*5-1:0]      disp_dest_reg,
  input  logic [DISP_WIDTH-1:0]        disp_wb_en,
  input  logic [DISP_WIDTH*32-1:0]     disp_pc,
  output logic                         disp_ready,
  output logic [DISP_WIDTH*IDXW-1:0]   disp_idx,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDXW-1:0]     wb_idx,
  input  logic [WB_PORTS*32-1:0]       wb_result,
  input  logic [WB_PORTS-1:0]          wb_mispred,
  input  logic [WB_PORTS-1:0]          wb_exception,
  output logic [RETIRE_WIDTH-1:0]      ret_valid,
  output logic [RETIRE_WIDTH*5-1:0]    ret_dest_reg,
  output logic [RETIRE_WIDTH-1:0]      ret_wb_en,
  output logic [RETIRE_WIDTH*32-1:0]   ret_result,
  output logic [RETIRE_WIDTH*32-1:0]   ret_pc,
  output logic                         flush,
  output logic [31:0]                  flush_pc,
  output logic                         flush_cause,
  output logic                         empty,
  output logic [31:0]                  perf_retired,
  output logic [31:0]                  perf_full_cycles,
  output logic [15:0]                  perf_flushes
);

  // Pointers and occupancy; head == tail is resolved by count.
  logic [IDXW-1:0] head;
  logic [IDXW-1:0] tail;
  logic [IDXW:0]   count;

  // Per-entry status bits (reset) and payload (no reset needed).
  logic [ROB_ENTRIES-1:0] ent_valid;
  logic [ROB_ENTRIES-1:0] ent_ready;
  logic [ROB_ENTRIES-1:0] ent_mispred;
  logic [ROB_ENTRIES-1:0] ent_exc;
  logic [ROB_ENTRIES-1:0] ent_wb_en;
  logic [4:0]             ent_dest   [ROB_ENTRIES];
  logic [31:0]            ent_pc     [ROB_ENTRIES];
  logic [31:0]            ent_result [ROB_ENTRIES];

  logic [IDXW:0]   disp_cnt;
  logic [IDXW:0]   ret_cnt;
  logic [IDXW:0]   free_cnt;
  logic            disp_acc;
  logic            fault;
  logic [31:0]     fault_pc;
  logic            fault_cause;
  logic            ret_go;
  logic [IDXW-1:0] ret_idx [RETIRE_WIDTH];

  assign free_cnt   = (IDXW+1)'(ROB_ENTRIES) - count;
  assign disp_ready = (free_cnt >= (IDXW+1)'(DISP_WIDTH));
  assign empty      = (count == {(IDXW+1){1'b0}});
  // A flushing retire discards the dispatch group presented alongside it.
  assign disp_acc   = disp_ready && !fault;

  // Compact valid dispatch lanes onto consecutive indices starting at tail.
  always_comb begin
    disp_idx = '0;
    disp_cnt = '0;
    for (int l = 0; l < DISP_WIDTH; l++) begin
      disp_idx[l*IDXW +: IDXW] = tail + disp_cnt[IDXW-1:0];
      if (disp_valid[l]) begin
        disp_cnt = disp_cnt + (IDXW+1)'(1);
      end else begin
        disp_cnt = disp_cnt;
      end
    end
  end

  // Select the in-order retire group from head; a faulting entry ends the group.
  always_comb begin
    ret_valid    = '0;
    ret_dest_reg = '0;
    ret_wb_en    = '0;
    ret_result   = '0;
    ret_pc       = '0;
    ret_cnt      = '0;
    fault        = 1'b0;
    fault_pc     = 32'h0000_0000;
    fault_cause  = 1'b0;
    ret_go       = 1'b1;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ret_idx[k]             = head + IDXW'(k);
      ret_dest_reg[k*5 +: 5] = ent_dest[ret_idx[k]];
      ret_wb_en[k]           = ent_wb_en[ret_idx[k]];
      ret_result[k*32 +: 32] = ent_result[ret_idx[k]];
      ret_pc[k*32 +: 32]     = ent_pc[ret_idx[k]];
      if (ret_go && ent_valid[ret_idx[k]] && ent_ready[ret_idx[k]]) begin
        ret_valid[k] = 1'b1;
        ret_cnt      = ret_cnt + (IDXW+1)'(1);
        if (ent_mispred[ret_idx[k]] || ent_exc[ret_idx[k]]) begin
          fault       = 1'b1;
          fault_pc    = ent_pc[ret_idx[k]];
          fault_cause = ent_exc[ret_idx[k]];
          ret_go      = 1'b0;
        end else begin
          ret_go      = 1'b1;
        end
      end else begin
        ret_go = 1'b0;
      end
    end
  end

  // Pointer, occupancy, status-bit and flush-pulse state.
  // Update order inside the cycle: writeback, then retire-clear, then
  // allocation, so a slot freed and reallocated in the same cycle comes out new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ent_valid   <= '0;
      ent_ready   <= '0;
      ent_mispred <= '0;
      ent_exc     <= '0;
      flush       <= 1'b0;
      flush_pc    <= 32'h0000_0000;
      flush_cause <= 1'b0;
    end else begin
      flush <= fault;
      if (fault) begin
        flush_pc    <= fault_pc;
        flush_cause <= fault_cause;
        ent_valid   <= '0;
        ent_ready   <= '0;
        head        <= head + ret_cnt[IDXW-1:0];
        tail        <= head + ret_cnt[IDXW-1:0];
        count       <= '0;
      end else begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && ent_valid[wb_idx[p*IDXW +: IDXW]]) begin
            ent_ready[wb_idx[p*IDXW +: IDXW]]   <= 1'b1;
            ent_mispred[wb_idx[p*IDXW +: IDXW]] <= wb_mispred[p];
            ent_exc[wb_idx[p*IDXW +: IDXW]]     <= wb_exception[p];
          end
        end
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
          if (ret_valid[k]) begin
            ent_valid[ret_idx[k]] <= 1'b0;
            ent_ready[ret_idx[k]] <= 1'b0;
          end
        end
        if (disp_acc) begin
          for (int l = 0; l < DISP_WIDTH; l++) begin
            if (disp_valid[l]) begin
              ent_valid[disp_idx[l*IDXW +: IDXW]]   <= 1'b1;
              ent_ready[disp_idx[l*IDXW +: IDXW]]   <= 1'b0;
              ent_mispred[disp_idx[l*IDXW +: IDXW]] <= 1'b0;
              ent_exc[disp_idx[l*IDXW +: IDXW]]     <= 1'b0;
            end
          end
          tail  <= tail + disp_cnt[IDXW-1:0];
          count <= count + disp_cnt - ret_cnt;
        end else begin
          count <= count - ret_cnt;
        end
        head <= head + ret_cnt[IDXW-1:0];
      end
    end
  end

  // Entry payload: results from writeback, instruction data from allocation.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && ent_valid[wb_idx[p*IDXW +: IDXW]]) begin
        ent_result[wb_idx[p*IDXW +: IDXW]] <= wb_result[p*32 +: 32];
      end
    end
    if (disp_acc) begin
      for (int l = 0; l < DISP_WIDTH; l++) begin
        if (disp_valid[l]) begin
          ent_dest[disp_idx[l*IDXW +: IDXW]]  <= disp_dest_reg[l*5 +: 5];
          ent_wb_en[disp_idx[l*IDXW +: IDXW]] <= disp_wb_en[l];
          ent_pc[disp_idx[l*IDXW +: IDXW]]    <= disp_pc[l*32 +: 32];
        end
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [32:0] perf_ret_sum;
  assign perf_ret_sum = {1'b0, perf_retired} + 33'(ret_cnt);

  // Saturating counters for retired lanes, stalled dispatch cycles and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired     <= 32'h0000_0000;
      perf_full_cycles <= 32'h0000_0000;
      perf_flushes     <= 16'h0000;
    end else begin
      if (perf_ret_sum[32]) begin
        perf_retired <= 32'hFFFF_FFFF;
      end else begin
        perf_retired <= perf_ret_sum[31:0];
      end
      if (!disp_ready && (|disp_valid) && (perf_full_cycles != 32'hFFFF_FFFF)) begin
        perf_full_cycles <= perf_full_cycles + 32'h0000_0001;
      end else begin
        perf_full_cycles <= perf_full_cycles;
      end
      if (fault && (perf_flushes != 16'hFFFF)) begin
        perf_flushes <= perf_flushes + 16'h0001;
      end else begin
        perf_flushes <= perf_flushes;
      end
    end
  end
`else
  assign perf_retired     = 32'h0000_0000;
  assign perf_full_cycles = 32'h0000_0000;
  assign perf_flushes     = 16'h0000;
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// Directed self-checking bench for rob_multiport (default parameters:
// 16 entries, 2 dispatch lanes, 2 retire lanes, 4 writeback ports).
module tb_rob_multiport;

  logic        clk;
  logic        rst_n;
  logic [1:0]  disp_valid;
  logic [9:0]  disp_dest_reg;
  logic [1:0]  disp_wb_en;
  logic [63:0] disp_pc;
  logic        disp_ready;
  logic [7:0]  disp_idx;
  logic [3:0]  wb_valid;
  logic [15:0] wb_idx;
  logic [127:0] wb_result;
  logic [3:0]  wb_mispred;
  logic [3:0]  wb_exception;
  logic [1:0]  ret_valid;
  logic [9:0]  ret_dest_reg;
  logic [1:0]  ret_wb_en;
  logic [63:0] ret_result;
  logic [63:0] ret_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        flush_cause;
  logic        empty;
  logic [31:0] perf_retired;
  logic [31:0] perf_full_cycles;
  logic [15:0] perf_flushes;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ROB_PERF_CNT_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  rob_multiport dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_dest_reg(disp_dest_reg), .disp_wb_en(disp_wb_en),
    .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_result(wb_result),
    .wb_mispred(wb_mispred), .wb_exception(wb_exception),
    .ret_valid(ret_valid), .ret_dest_reg(ret_dest_reg), .ret_wb_en(ret_wb_en),
    .ret_result(ret_result), .ret_pc(ret_pc),
    .flush(flush), .flush_pc(flush_pc), .flush_cause(flush_cause), .empty(empty),
    .perf_retired(perf_retired), .perf_full_cycles(perf_full_cycles), .perf_flushes(perf_flushes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    disp_valid = 2'b00; disp_dest_reg = 10'd0; disp_wb_en = 2'b00; disp_pc = 64'd0;
    wb_valid = 4'b0000; wb_idx = 16'd0; wb_result = 128'd0;
    wb_mispred = 4'b0000; wb_exception = 4'b0000;
  endtask

  task automatic drive_disp(input int lane, input logic [31:0] pc, input logic [4:0] dest, input logic wben);
    disp_valid[lane] = 1'b1;
    disp_pc[lane*32 +: 32] = pc;
    disp_dest_reg[lane*5 +: 5] = dest;
    disp_wb_en[lane] = wben;
  endtask

  task automatic drive_wb(input int port, input logic [3:0] idx, input logic [31:0] res, input logic mis, input logic exc);
    wb_valid[port] = 1'b1;
    wb_idx[port*4 +: 4] = idx;
    wb_result[port*32 +: 32] = res;
    wb_mispred[port] = mis;
    wb_exception[port] = exc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL reset_ret_valid: got %b expected 00", ret_valid); end
    n_checks++; if ({flush, flush_cause, flush_pc} !== 34'd0) begin n_fail++; $display("FAIL reset_flush: got %b %b %h expected 0 0 0", flush, flush_cause, flush_pc); end
    n_checks++; if (disp_idx !== 8'h00) begin n_fail++; $display("FAIL reset_disp_idx: got %h expected 00", disp_idx); end
  endtask

  task automatic test_fill_drain();
    logic [7:0]  exp_idx;
    logic [63:0] exp64;
    for (int c = 0; c < 8; c++) begin
      clear_in();
      drive_disp(0, 32'h400 + 32'(8*c), 5'(2*c+1), 1'b1);
      drive_disp(1, 32'h404 + 32'(8*c), 5'(2*c+2), 1'b0);
      #1;
      exp_idx = {4'(2*c+1), 4'(2*c)};
      n_checks++; if (disp_idx !== exp_idx) begin n_fail++; $display("FAIL fill_idx c=%0d: got %h expected %h", c, disp_idx, exp_idx); end
      n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready c=%0d: got %b expected 1", c, disp_ready); end
      tick();
    end
    clear_in();
    drive_disp(0, 32'hDEAD_0000, 5'd31, 1'b1);
    drive_disp(1, 32'hDEAD_0004, 5'd30, 1'b1);
    #1;
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", disp_ready); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", empty); end
    tick();
    for (int w = 0; w < 4; w++) begin
      clear_in();
      for (int p = 0; p < 4; p++) begin
        drive_wb(p, 4'(15-4*w-p), 32'h1000 + 32'(15-4*w-p), 1'b0, 1'b0);
      end
      #1;
      n_checks++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL wb_no_retire w=%0d: got %b expected 00", w, ret_valid); end
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      clear_in();
      #1;
      n_checks++; if (ret_valid !== 2'b11) begin n_fail++; $display("FAIL drain_valid c=%0d: got %b expected 11", c, ret_valid); end
      exp64 = {32'h404 + 32'(8*c), 32'h400 + 32'(8*c)};
      n_checks++; if (ret_pc !== exp64) begin n_fail++; $display("FAIL drain_pc c=%0d: got %h expected %h", c, ret_pc, exp64); end
      exp64 = {32'h1000 + 32'(2*c+1), 32'h1000 + 32'(2*c)};
      n_checks++; if (ret_result !== exp64) begin n_fail++; $display("FAIL drain_result c=%0d: got %h expected %h", c, ret_result, exp64); end
      n_checks++; if (ret_dest_reg !== {5'(2*c+2), 5'(2*c+1)}) begin n_fail++; $display("FAIL drain_dest c=%0d: got %h expected %h", c, ret_dest_reg, {5'(2*c+2), 5'(2*c+1)}); end
      n_checks++; if (ret_wb_en !== 2'b01) begin n_fail++; $display("FAIL drain_wb_en c=%0d: got %b expected 01", c, ret_wb_en); end
      tick();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drained_empty: got %b expected 1", empty); end
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL drained_ready: got %b expected 1", disp_ready); end
    n_checks++; if (perf_retired !== 32'(16*PERF_ON)) begin n_fail++; $display("FAIL perf_retired_fill: got %0d expected %0d", perf_retired, 16*PERF_ON); end
    n_checks++; if (perf_full_cycles !== 32'(PERF_ON)) begin n_fail++; $display("FAIL perf_full: got %0d expected %0d", perf_full_cycles, PERF_ON); end
  endtask

  task automatic test_out_of_order();
    clear_in();
    drive_disp(0, 32'h200, 5'd1, 1'b1); drive_disp(1, 32'h204, 5'd2, 1'b1);
    #1;
    n_checks++; if (disp_idx !== 8'h10) begin n_fail++; $display("FAIL ooo_idx01: got %h expected 10", disp_idx); end
    tick();
    clear_in();
    drive_disp(0, 32'h208, 5'd3, 1'b1); drive_disp(1, 32'h20C, 5'd4, 1'b1);
    #1;
    n_checks++; if (disp_idx !== 8'h32) begin n_fail++; $display("FAIL ooo_idx23: got %h expected 32", disp_idx); end
    tick();
    clear_in();
    drive_wb(0, 4'd3, 32'h2003, 1'b0, 1'b0); drive_wb(1, 4'd2, 32'h2002, 1'b0, 1'b0); drive_wb(2, 4'd1, 32'h2001, 1'b0, 1'b0);
    tick();
    clear_in();
    #1;
    n_checks++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_blocked: got %b expected 00", ret_valid); end
    drive_wb(0, 4'd0, 32'h2000, 1'b0, 1'b0);
    tick();
    clear_in();
    #1;
    n_checks++; if (ret_valid !== 2'b11) begin n_fail++; $display("FAIL ooo_ret01_valid: got %b expected 11", ret_valid); end
    n_checks++; if (ret_pc !== 64'h0000_0204_0000_0200) begin n_fail++; $display("FAIL ooo_ret01_pc: got %h expected 0000020400000200", ret_pc); end
    tick();
    n_checks++; if (ret_valid !== 2'b11) begin n_fail++; $display("FAIL ooo_ret23_valid: got %b expected 11", ret_valid); end
    n_checks++; if (ret_result !== 64'h0000_2003_0000_2002) begin n_fail++; $display("FAIL ooo_ret23_result: got %h expected 0000200300002002", ret_result); end
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ooo_empty: got %b expected 1", empty); end
  endtask

  task automatic test_flush();
    clear_in();
    drive_disp(0, 32'h0FC, 5'd7, 1'b1);
    #1;
    n_checks++; if (disp_idx[3:0] !== 4'd4) begin n_fail++; $display("FAIL fl_idx4: got %0d expected 4", disp_idx[3:0]); end
    tick();
    clear_in();
    drive_wb(0, 4'd4, 32'h44, 1'b0, 1'b0);
    tick();
    clear_in();
    #1;
    n_checks++; if (ret_valid !== 2'b01 || ret_pc[31:0] !== 32'h0FC) begin n_fail++; $display("FAIL fl_pre_retire: got %b %h expected 01 000000fc", ret_valid, ret_pc[31:0]); end
    drive_disp(0, 32'h100, 5'd8, 1'b1); drive_disp(1, 32'h104, 5'd9, 1'b1);
    #1;
    n_checks++; if (disp_idx !== 8'h65) begin n_fail++; $display("FAIL fl_idx56: got %h expected 65", disp_idx); end
    tick();
    clear_in();
    drive_wb(0, 4'd5, 32'h55, 1'b1, 1'b0); drive_wb(1, 4'd6, 32'h66, 1'b0, 1'b0);
    tick();
    clear_in();
    drive_disp(0, 32'h900, 5'd10, 1'b1); drive_disp(1, 32'h904, 5'd11, 1'b1);
    #1;
    n_checks++; if (ret_valid !== 2'b01) begin n_fail++; $display("FAIL fl_lane_suppress: got %b expected 01", ret_valid); end
    n_checks++; if (ret_pc[31:0] !== 32'h100) begin n_fail++; $display("FAIL fl_ret_pc: got %h expected 00000100", ret_pc[31:0]); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL fl_not_yet: got %b expected 0", flush); end
    tick();
    clear_in();
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL fl_pulse: got %b expected 1", flush); end
    n_checks++; if (flush_pc !== 32'h100 || flush_cause !== 1'b0) begin n_fail++; $display("FAIL fl_pc_cause: got %h %b expected 00000100 0", flush_pc, flush_cause); end
    n_checks++; if (empty !== 1'b1 || ret_valid !== 2'b00) begin n_fail++; $display("FAIL fl_cleared: got empty=%b ret=%b expected 1 00", empty, ret_valid); end
    n_checks++; if (disp_idx[3:0] !== 4'd6) begin n_fail++; $display("FAIL fl_new_tail: got %0d expected 6", disp_idx[3:0]); end
    tick();
    n_checks++; if (flush !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL fl_one_cycle: got flush=%b empty=%b expected 0 1", flush, empty); end
    drive_disp(0, 32'h300, 5'd12, 1'b1);
    tick();
    clear_in();
    drive_wb(2, 4'd6, 32'h77, 1'b1, 1'b1);
    tick();
    clear_in();
    #1;
    n_checks++; if (ret_valid !== 2'b01) begin n_fail++; $display("FAIL exc_retire: got %b expected 01", ret_valid); end
    tick();
    n_checks++; if (flush !== 1'b1 || flush_cause !== 1'b1 || flush_pc !== 32'h300) begin n_fail++; $display("FAIL exc_flush: got %b %b %h expected 1 1 00000300", flush, flush_cause, flush_pc); end
    tick();
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 4; c++) begin
      clear_in();
      drive_disp(0, 32'h500 + 32'(8*c), 5'd1, 1'b1);
      if (c < 3) drive_disp(1, 32'h504 + 32'(8*c), 5'd2, 1'b1);
      tick();
    end
    clear_in();
    for (int p = 0; p < 4; p++) drive_wb(p, 4'(7+p), 32'h0, 1'b0, 1'b0);
    tick();
    clear_in();
    for (int p = 0; p < 3; p++) drive_wb(p, 4'(11+p), 32'h0, 1'b0, 1'b0);
    tick();
    clear_in();
    repeat (6) tick();
    n_checks++; if (empty !== 1'b1 || disp_idx[3:0] !== 4'd14) begin n_fail++; $display("FAIL wrap_setup: got empty=%b tail=%0d expected 1 14", empty, disp_idx[3:0]); end
    drive_disp(0, 32'h638, 5'd14, 1'b1); drive_disp(1, 32'h63C, 5'd15, 1'b1);
    #1;
    n_checks++; if (disp_idx !== 8'hFE) begin n_fail++; $display("FAIL wrap_idx1415: got %h expected fe", disp_idx); end
    tick();
    clear_in();
    drive_disp(0, 32'h600, 5'd16, 1'b1); drive_disp(1, 32'h604, 5'd17, 1'b1);
    #1;
    n_checks++; if (disp_idx !== 8'h10) begin n_fail++; $display("FAIL wrap_idx01: got %h expected 10", disp_idx); end
    tick();
    clear_in();
    drive_wb(0, 4'd14, 32'hE0E, 1'b0, 1'b0); drive_wb(1, 4'd15, 32'hE0F, 1'b0, 1'b0);
    drive_wb(2, 4'd0, 32'hE00, 1'b0, 1'b0); drive_wb(3, 4'd1, 32'hE01, 1'b0, 1'b0);
    tick();
    clear_in();
    #1;
    n_checks++; if (ret_valid !== 2'b11 || ret_pc !== 64'h0000_063C_0000_0638) begin n_fail++; $display("FAIL wrap_ret1415_pc: got %b %h expected 11 0000063c00000638", ret_valid, ret_pc); end
    n_checks++; if (ret_result !== 64'h0000_0E0F_0000_0E0E) begin n_fail++; $display("FAIL wrap_ret1415_res: got %h expected 00000e0f00000e0e", ret_result); end
    tick();
    n_checks++; if (ret_valid !== 2'b11 || ret_pc !== 64'h0000_0604_0000_0600) begin n_fail++; $display("FAIL wrap_ret01_pc: got %b %h expected 11 0000060400000600", ret_valid, ret_pc); end
    n_checks++; if (ret_result !== 64'h0000_0E01_0000_0E00) begin n_fail++; $display("FAIL wrap_ret01_res: got %h expected 00000e0100000e00", ret_result); end
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_port_conflict();
    clear_in();
    drive_disp(0, 32'hA00, 5'd3, 1'b1);
    #1;
    n_checks++; if (disp_idx[3:0] !== 4'd2) begin n_fail++; $display("FAIL pc_idx: got %0d expected 2", disp_idx[3:0]); end
    tick();
    clear_in();
    drive_wb(1, 4'd2, 32'hA, 1'b0, 1'b0);
    drive_wb(3, 4'd2, 32'hB, 1'b0, 1'b0);
    drive_wb(0, 4'd9, 32'hBAD, 1'b1, 1'b1);
    tick();
    clear_in();
    #1;
    n_checks++; if (ret_valid !== 2'b01) begin n_fail++; $display("FAIL pc_valid: got %b expected 01", ret_valid); end
    n_checks++; if (ret_result[31:0] !== 32'hB) begin n_fail++; $display("FAIL pc_result: got %h expected 0000000b", ret_result[31:0]); end
    tick();
    n_checks++; if (flush !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL pc_no_flush: got flush=%b empty=%b expected 0 1", flush, empty); end
    n_checks++; if (perf_retired !== 32'(35*PERF_ON) || perf_flushes !== 16'(2*PERF_ON)) begin n_fail++; $display("FAIL perf_totals: got %0d %0d expected %0d %0d", perf_retired, perf_flushes, 35*PERF_ON, 2*PERF_ON); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 5; c++) begin
      clear_in();
      drive_disp(0, 32'hC00 + 32'(8*c), 5'd5, 1'b1);
      if (c < 4) drive_disp(1, 32'hC04 + 32'(8*c), 5'd6, 1'b1);
      tick();
    end
    clear_in();
    drive_wb(0, 4'd3, 32'h33, 1'b0, 1'b0);
    tick();
    clear_in();
    #1;
    n_checks++; if (ret_valid !== 2'b01 || empty !== 1'b0) begin n_fail++; $display("FAIL ar_pre: got ret=%b empty=%b expected 01 0", ret_valid, empty); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ret_valid !== 2'b00 || empty !== 1'b1 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL ar_state: got ret=%b empty=%b ready=%b expected 00 1 1", ret_valid, empty, disp_ready); end
    n_checks++; if (disp_idx !== 8'h00 || flush !== 1'b0) begin n_fail++; $display("FAIL ar_ptr: got idx=%h flush=%b expected 00 0", disp_idx, flush); end
    n_checks++; if ({perf_retired, perf_full_cycles, perf_flushes} !== 80'd0) begin n_fail++; $display("FAIL ar_perf: got %0d %0d %0d expected 0 0 0", perf_retired, perf_full_cycles, perf_flushes); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive_disp(0, 32'hF00, 5'd1, 1'b1); drive_disp(1, 32'hF04, 5'd2, 1'b1);
    #1;
    n_checks++; if (disp_idx !== 8'h10) begin n_fail++; $display("FAIL ar_redispatch: got %h expected 10", disp_idx); end
    tick();
    clear_in();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_out_of_order();
    test_flush();
    test_wrap();
    test_port_conflict();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised successor of the single-issue reorder buffer.
- Circular ROB with DISP_WIDTH-wide in-order allocation, WB_PORTS out-of-order completion ports and RETIRE_WIDTH-wide in-order retirement.
- Precise flush when a mispredicted or excepting entry retires.
- Sits between rename/dispatch, the FU writeback bus and the architectural commit/free-list logic.

Parameters:
- ROB_ENTRIES, 16, entry count; must be a power of 2, at least 4.
- DISP_WIDTH, 2, dispatch lanes per cycle.
- RETIRE_WIDTH, 2, retire lanes per cycle.
- WB_PORTS, 4, writeback ports (one per FU).
- IDXW, $clog2(ROB_ENTRIES), entry index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- disp_valid  in  DISP_WIDTH  per-lane allocate request.
- disp_dest_reg  in  DISP_WIDTH*5  architectural destination.
- disp_wb_en  in  DISP_WIDTH  entry writes a register.
- disp_pc  in  DISP_WIDTH*32  instruction PC.
- disp_ready  out  1  free entries >= DISP_WIDTH.
- disp_idx  out  DISP_WIDTH*IDXW  index allocated to each valid lane.
- wb_valid  in  WB_PORTS  completion strobe.
- wb_idx  in  WB_PORTS*IDXW  completing entry.
- wb_result  in  WB_PORTS*32  result value.
- wb_mispred  in  WB_PORTS  branch mispredicted.
- wb_exception  in  WB_PORTS  exception raised.
- ret_valid  out  RETIRE_WIDTH  lane retires this cycle.
- ret_dest_reg  out  RETIRE_WIDTH*5  destination.
- ret_wb_en  out  RETIRE_WIDTH  register write enable.
- ret_result  out  RETIRE_WIDTH*32  value to commit.
- ret_pc  out  RETIRE_WIDTH*32  retiring PC.
- flush  out  1  registered one-cycle flush pulse.
- flush_pc  out  32  PC of the offending entry.
- flush_cause  out  1  0 = mispredict, 1 = exception.
- empty  out  1  count == 0.

Behaviour:

Reset:
- head, tail and count are 0; all entry valid/ready bits are 0.
- flush = 0, flush_pc = 0, flush_cause = 0.
- disp_ready = 1, empty = 1, ret_valid = 0.

Dispatch:
- Accepted at the clock edge only when disp_ready = 1.
- Valid lanes are compacted in lane order: the k-th valid lane gets index (tail+k) mod ROB_ENTRIES. disp_idx for that lane is combinational from tail.
- tail advances by popcount(disp_valid).
- A new entry is written with valid = 1, ready = 0, mispred = 0, exception = 0.
- Requests made while disp_ready = 0 are ignored.

Writeback:
- Each wb_valid port at the edge sets ready = 1 and stores result, mispred and exception for its entry.
- Writeback to an invalid entry is ignored.
- If two ports target the same index in one cycle, the higher port number wins.
- An entry written back this cycle is not retire-eligible until the next cycle; there is no bypass.

Retire:
- Combinational from registered state.
- Lane k is valid iff entries head..head+k are all valid and ready, and no earlier lane this cycle carries mispred or exception.
- A faulting entry retires in its own lane, and later lanes are suppressed.
- At the edge: head advances by the retired count, and those entries are cleared.

Flush:
- Trigger: a retiring lane has mispred or exception.
- At the same edge:
  - all remaining entries are invalidated;
  - tail = head = old head + retired count, and count = 0;
  - any dispatch presented in that cycle is discarded;
  - flush = 1 for exactly one cycle, with flush_pc and flush_cause captured.
- If both mispred and exception are set on the entry, flush_cause = 1.

Count:
- next_count = count + dispatched − retired, computed with IDXW+1 bits; never exceeds ROB_ENTRIES.
- Simultaneous dispatch and retire when full is legal: disp_ready reflects the pre-edge count.

Wrap-around:
- Index arithmetic is modulo ROB_ENTRIES.
- head == tail is disambiguated by count.

Mid-operation reset:
- Asynchronous assertion returns all state to its reset values immediately.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_retired (32 bit): total lanes retired, saturating.
  - perf_full_cycles (32 bit): cycles with disp_ready = 0 and at least one disp_valid.
  - perf_flushes (16 bit): flush pulses, saturating.
  - All three reset to 0.
- When undefined, the ports still exist, are driven constant 0, and no counter flops are inferred.

Test Plan:
1. Fill/drain: dispatch 2 per cycle for 8 cycles (ROB_ENTRIES=16) -> disp_ready=0 after 8th, disp_idx 0..15; writeback all, then 2 retire per cycle for 8 cycles in order, empty=1.
2. Out-of-order writeback: dispatch idx 0..3, writeback 3,2,1 -> no retire; writeback 0 -> next cycle ret_valid=2'b11 (0,1), then (2,3).
3. Mispredict: idx 5 mispred with pc=0x100, idx 5 and 6 ready at head -> only lane 0 retires idx 5; flush=1, flush_pc=0x100, flush_cause=0 next cycle; count=0; same-cycle dispatch dropped.
4. Wrap: steady state with head=14 -> dispatch gives idx 14,15 then 0,1; retire order 14,15,0,1 correct.
5. Port conflict: wb ports 1 and 3 both target idx 2, results 0xA and 0xB -> ret_result=0xB.
6. Async reset mid-fill with count=9 -> all outputs at reset values before next clk edge; perf counters (ROB_PERF_CNT_EN) cleared.
